// File: rtl/obi_sub_pkg.sv
// rtl/obi_sub_pkg.sv - default parameters and response-entry sizing for obi_sub_mem
package obi_sub_pkg;

  localparam int unsigned OBI_ADDR_W    = 32;
  localparam int unsigned OBI_DATA_W    = 32;
  localparam int unsigned OBI_ID_W      = 1;
  localparam int unsigned OBI_DEPTH     = 1024;
  localparam int unsigned OBI_MAX_OUT   = 4;
  localparam int unsigned OBI_BASE_ADDR = 0;

  // Queued response entry is {rdata, err, rid}.
  function automatic int unsigned resp_entry_w(input int unsigned data_w, input int unsigned id_w);
    return data_w + 1 + id_w;
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// rtl/obi_resp_fifo.sv - synchronous FIFO with occupancy count, head visible on o_data
module obi_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_sub_mem.sv
// rtl/obi_sub_mem.sv - OBI subordinate word memory with in-order queued responses
module obi_sub_mem
  import obi_sub_pkg::*;
#(
  parameter int unsigned ADDR_W    = OBI_ADDR_W,
  parameter int unsigned DATA_W    = OBI_DATA_W,
  parameter int unsigned ID_W      = OBI_ID_W,
  parameter int unsigned DEPTH     = OBI_DEPTH,
  parameter int unsigned MAX_OUT   = OBI_MAX_OUT,
  parameter int unsigned BASE_ADDR = OBI_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_obi_req,
  output logic                s_obi_gnt,
  input  logic [ADDR_W-1:0]   s_obi_addr,
  input  logic                s_obi_we,
  input  logic [DATA_W/8-1:0] s_obi_be,
  input  logic [DATA_W-1:0]   s_obi_wdata,
  input  logic [ID_W-1:0]     s_obi_aid,
  output logic                s_obi_rvalid,
  input  logic                s_obi_rready,
  output logic [DATA_W-1:0]   s_obi_rdata,
  output logic                s_obi_err,
  output logic [ID_W-1:0]     s_obi_rid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BE_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = resp_entry_w(DATA_W, ID_W);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [ADDR_W-1:0] L_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_DEPTH    = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LOW_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_accept;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdata;
  logic [ENT_W-1:0]  w_push_data;
  logic [ENT_W-1:0]  w_head;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  assign w_off  = s_obi_addr - L_BASE;
  assign w_word = w_off >> LSB;
  assign w_idx  = w_word[IDX_W-1:0];
  assign w_err  = (s_obi_addr < L_BASE) || (w_word >= L_DEPTH) ||
                  ((s_obi_addr & L_LOW_MASK) != '0);

  // No pop bypass: a slot freed this cycle is only granted next cycle.
  assign s_obi_gnt = (w_count < CNT_W'(MAX_OUT)) && !rst;
  assign w_accept  = s_obi_req && s_obi_gnt;
  assign w_pop     = s_obi_rvalid && s_obi_rready;

  assign w_rdata     = (s_obi_we || w_err) ? '0 : r_mem[w_idx];
  assign w_push_data = {w_rdata, w_err, s_obi_aid};

  always_ff @(posedge clk) begin
    if (w_accept && s_obi_we && !w_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (s_obi_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= s_obi_wdata[b*8 +: 8];
        end
      end
    end
  end

  obi_resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (MAX_OUT)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign s_obi_rvalid = !w_empty;
  assign {s_obi_rdata, s_obi_err, s_obi_rid} = s_obi_rvalid ? w_head : '0;

endmodule

// File: tb/tb_obi_sub_mem.sv
// tb/tb_obi_sub_mem.sv - self-checking bench for obi_sub_mem against a byte-array/queue model
module tb_obi_sub_mem;

  localparam int DEPTH   = 1024;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        id;
    int          cyc;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        s_obi_req;
  logic        s_obi_gnt;
  logic [31:0] s_obi_addr;
  logic        s_obi_we;
  logic [3:0]  s_obi_be;
  logic [31:0] s_obi_wdata;
  logic        s_obi_aid;
  logic        s_obi_rvalid;
  logic        s_obi_rready;
  logic [31:0] s_obi_rdata;
  logic        s_obi_err;
  logic        s_obi_rid;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] mb [DEPTH*4];
  ev_t mq[$];
  ev_t pop_log[$];
  int  acc_cyc[$];

  obi_sub_mem dut (
    .clk          (clk),
    .rst          (rst),
    .s_obi_req    (s_obi_req),
    .s_obi_gnt    (s_obi_gnt),
    .s_obi_addr   (s_obi_addr),
    .s_obi_we     (s_obi_we),
    .s_obi_be     (s_obi_be),
    .s_obi_wdata  (s_obi_wdata),
    .s_obi_aid    (s_obi_aid),
    .s_obi_rvalid (s_obi_rvalid),
    .s_obi_rready (s_obi_rready),
    .s_obi_rdata  (s_obi_rdata),
    .s_obi_err    (s_obi_err),
    .s_obi_rid    (s_obi_rid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: byte-addressed memory plus an in-order list of owed responses.
  always @(posedge clk or posedge rst) begin
    ev_t r;
    int  a;
    bit  acc;
    bit  pop;
    if (rst) begin
      mq.delete();
    end else begin
      acc = s_obi_req && (mq.size() < MAX_OUT);
      pop = (mq.size() > 0) && s_obi_rready;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        a = int'(s_obi_addr);
        r.e = (s_obi_addr % 4 != 0) || (s_obi_addr / 4 >= DEPTH);
        r.d = '0;
        r.id = s_obi_aid;
        r.cyc = 0;
        if (!r.e && s_obi_we) begin
          for (int b = 0; b < 4; b++) if (s_obi_be[b]) mb[a+b] = s_obi_wdata[b*8 +: 8];
        end else if (!r.e) begin
          r.d = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        end
        mq.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    ev_t h;
    if (s_obi_req && s_obi_gnt) acc_cyc.push_back(cyc);
    if (s_obi_rvalid && s_obi_rready) begin
      h.d = s_obi_rdata; h.e = s_obi_err; h.id = s_obi_rid; h.cyc = cyc;
      pop_log.push_back(h);
    end
    chk("gnt", {63'd0, s_obi_gnt}, {63'd0, !rst && (mq.size() < MAX_OUT)});
    chk("rvalid", {63'd0, s_obi_rvalid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0)
      chk("rsp_head", {s_obi_rdata, s_obi_err, s_obi_rid}, {mq[0].d, mq[0].e, mq[0].id});
    else
      chk("rsp_idle", {s_obi_rdata, s_obi_err, s_obi_rid}, 64'd0);
  end

  task automatic obi(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input logic id);
    int  n = 0;
    bit  ok = 0;
    s_obi_req = 1'b1; s_obi_addr = a; s_obi_we = we;
    s_obi_be = be; s_obi_wdata = wd; s_obi_aid = id;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_obi_gnt;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    s_obi_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input string nm, input int k, input logic [31:0] d,
                            input logic e, input logic id);
    if (k >= pop_log.size()) chk({nm, "_missing"}, 64'(pop_log.size()), 64'(k + 1));
    else chk(nm, {pop_log[k].d, pop_log[k].e, pop_log[k].id}, {d, e, id});
  endtask

  initial begin
    int  b;
    int  ba;
    int  n;
    bit  done;
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    rst = 1'b1; s_obi_req = 1'b0; s_obi_addr = '0; s_obi_we = 1'b0;
    s_obi_be = '0; s_obi_wdata = '0; s_obi_aid = 1'b0; s_obi_rready = 1'b1;
    idle(3);
    chk("reset_outputs", {s_obi_gnt, s_obi_rvalid, s_obi_rdata, s_obi_err, s_obi_rid}, 64'd0);
    rst = 1'b0;

    // Full write then read back; first request issued right after reset release.
    b = pop_log.size();
    obi(32'h4, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
    obi(32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    idle(4);
    expect_rsp("t20_wr", b, 32'h0, 1'b0, 1'b1);
    expect_rsp("t20_rd", b + 1, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte-lane partial write.
    b = pop_log.size();
    obi(32'h4, 1'b1, 4'h2, 32'h11223344, 1'b0);
    obi(32'h4, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(4);
    expect_rsp("t21_rd", b + 1, 32'hDEAD33EF, 1'b0, 1'b1);

    // Out-of-range and misaligned accesses.
    b = pop_log.size();
    obi(32'h0, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b0);
    obi(32'h1000, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1);
    obi(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
    obi(32'h2, 1'b0, 4'h0, 32'h0, 1'b1);
    obi(32'h2, 1'b1, 4'hF, 32'h12345678, 1'b0);
    obi(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    idle(4);
    expect_rsp("t23_wr_oor", b + 1, 32'h0, 1'b1, 1'b1);
    expect_rsp("t23_rd_oor", b + 2, 32'h0, 1'b1, 1'b0);
    expect_rsp("t23_rd_mis", b + 3, 32'h0, 1'b1, 1'b1);
    expect_rsp("t23_rd_ok", b + 5, 32'hA5A5A5A5, 1'b0, 1'b1);

    // Queue fills with rready low; fifth request waits for the first pop.
    obi(32'h8, 1'b1, 4'hF, 32'h88888888, 1'b0);
    obi(32'hC, 1'b1, 4'hF, 32'hCCCCCCCC, 1'b0);
    idle(3);
    s_obi_rready = 1'b0;
    b = pop_log.size();
    ba = acc_cyc.size();
    done = 0;
    fork
      begin
        obi(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        obi(32'h4, 1'b0, 4'h0, 32'h0, 1'b1);
        obi(32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
        obi(32'hC, 1'b0, 4'h0, 32'h0, 1'b1);
        obi(32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
        done = 1;
      end
    join_none
    idle(8);
    chk("t22_gnt_full", {63'd0, s_obi_gnt}, 64'd0);
    chk("t22_acc4", 64'(acc_cyc.size() - ba), 64'd4);
    s_obi_rready = 1'b1;
    n = 0;
    while (!done && n < 50) begin idle(1); n++; end
    chk("t22_done", {63'd0, done}, 64'd1);
    idle(6);
    expect_rsp("t22_r0", b, 32'hA5A5A5A5, 1'b0, 1'b0);
    expect_rsp("t22_r1", b + 1, 32'hDEAD33EF, 1'b0, 1'b1);
    expect_rsp("t22_r2", b + 2, 32'h88888888, 1'b0, 1'b0);
    expect_rsp("t22_r3", b + 3, 32'hCCCCCCCC, 1'b0, 1'b1);
    expect_rsp("t22_r4", b + 4, 32'h88888888, 1'b0, 1'b0);
    if (acc_cyc.size() >= ba + 5 && pop_log.size() > b)
      chk("t22_5th_after_pop", 64'(acc_cyc[ba+4]), 64'(pop_log[b].cyc + 1));
    else
      chk("t22_5th_missing", 64'(acc_cyc.size() - ba), 64'd5);

    // Reset with responses queued discards them.
    s_obi_rready = 1'b0;
    obi(32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    obi(32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    obi(32'h8, 1'b0, 4'h0, 32'h0, 1'b1);
    idle(1);
    rst = 1'b1;
    #1;
    chk("t24_rst_imm", {s_obi_gnt, s_obi_rvalid, s_obi_rdata, s_obi_err, s_obi_rid}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b = pop_log.size();
    s_obi_rready = 1'b1;
    idle(3);
    chk("t24_no_stale", 64'(pop_log.size() - b), 64'd0);
    obi(32'hC, 1'b0, 4'h0, 32'h0, 1'b1);
    idle(3);
    expect_rsp("t24_mem_kept", b, 32'hCCCCCCCC, 1'b0, 1'b1);

    // Streaming with rready high: one accept per cycle, rid one cycle behind.
    b = pop_log.size();
    ba = acc_cyc.size();
    obi(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    obi(32'h4, 1'b0, 4'h0, 32'h0, 1'b1);
    obi(32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
    obi(32'hC, 1'b0, 4'h0, 32'h0, 1'b1);
    idle(4);
    if (acc_cyc.size() >= ba + 4 && pop_log.size() >= b + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t25_rid", {63'd0, pop_log[b+k].id}, 64'(k % 2));
        chk("t25_lag", 64'(pop_log[b+k].cyc), 64'(acc_cyc[ba+k] + 1));
        if (k > 0) chk("t25_rate", 64'(acc_cyc[ba+k]), 64'(acc_cyc[ba+k-1] + 1));
      end
    end else begin
      chk("t25_count", 64'(pop_log.size() - b), 64'd4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
